if_id_pipe_stage: RTL and testbench

Parametrised fetch-to-decode pipeline register for the NOVA core, the successor to the single-register decode-state latch. Carries PC and instruction from fetch into decode with a valid/ready handshake, flush support and a stall performance counter. An optional two-entry skid buffer registers the upstream ready so that the stage sustains one instruction per cycle without a combinational ready path back into fetch.

---
 rtl/rapid_pkg.sv | 14 +
 rtl/if_id_pipe_stage_stall_counter.sv | 31 +++
 rtl/if_id_pipe_stage.sv | 118 +++++++++++
 tb/tb_if_id_pipe_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rapid_pkg.sv
// Shared NOVA front-end constants and the fetch-to-decode entry payload.
package rapid_pkg;

    localparam int unsigned RAPID_XLEN   = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_1000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic                  valid;
        logic [RAPID_XLEN-1:0] pc;
        logic [RAPID_XLEN-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_pipe_stage_stall_counter.sv
// Saturating up-counter used to count decode backpressure cycles.
module stall_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_pipe_stage.sv
// Fetch-to-decode pipeline register with valid/ready handshake, flush and stall counter.
// Define IF_ID_SKID_EN for the two-entry skid buffer with a registered o_ready.
module if_id_pipe_stage
    import rapid_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_VECTOR),
    parameter int unsigned     STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [XLEN-1:0]        i_pc,
    input  logic [XLEN-1:0]        i_instruction,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [XLEN-1:0]        o_pc,
    output logic [XLEN-1:0]        o_instruction,
    input  logic                   i_flush,
    output logic [STALL_CNT_W-1:0] o_stall_count
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    localparam logic [XLEN-1:0] NOP_W   = XLEN'(NOP_INSTR);
    localparam entry_t          M_RESET = '{valid: 1'b0, pc: RESET_PC, instr: NOP_W};

    entry_t m_q;
    entry_t m_d;
    entry_t in_entry;
    logic   in_xfer;
    logic   out_xfer;

    assign in_entry = '{valid: 1'b1, pc: i_pc, instr: i_instruction};
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = m_q.valid && i_ready;

`ifdef IF_ID_SKID_EN
    localparam entry_t S_RESET = '{valid: 1'b0, pc: '0, instr: NOP_W};

    entry_t s_q;
    entry_t s_d;

    // Skid entry always drains into M before new input so order is preserved.
    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (i_flush) begin
            m_d.valid = 1'b0;
            m_d.instr = NOP_W;
            s_d.valid = 1'b0;
        end else if (!m_q.valid || out_xfer) begin
            if (s_q.valid) begin
                m_d       = s_q;
                s_d.valid = 1'b0;
            end else if (in_xfer) begin
                m_d = in_entry;
            end else begin
                m_d.valid = 1'b0;
            end
        end else if (in_xfer) begin
            s_d = in_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s_q <= S_RESET;
        end else begin
            s_q <= s_d;
        end
    end

    assign o_ready = !s_q.valid;
`else
    always_comb begin
        m_d = m_q;
        if (i_flush) begin
            m_d.valid = 1'b0;
            m_d.instr = NOP_W;
        end else if (in_xfer) begin
            m_d = in_entry;
        end else if (out_xfer) begin
            m_d.valid = 1'b0;
        end
    end

    // Single-entry mode: ready looks through to decode when M is occupied.
    assign o_ready = !m_q.valid || i_ready;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_q <= M_RESET;
        end else begin
            m_q <= m_d;
        end
    end

    assign o_valid       = m_q.valid;
    assign o_pc          = m_q.pc;
    assign o_instruction = m_q.instr;

    stall_counter #(
        .W (STALL_CNT_W)
    ) u_stall_counter (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .inc   (m_q.valid && !i_ready),
        .count (o_stall_count)
    );

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Scoreboard bench for if_id_pipe_stage: capacity-based queue model, decoupled output monitor.
module tb_if_id_pipe_stage;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned SCW      = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0A00;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          STAL_MAX = (1 << SCW) - 1;
`ifdef IF_ID_SKID_EN
    localparam int          CAP      = 2;
`else
    localparam int          CAP      = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_valid, i_ready, i_flush;
    logic [XLEN-1:0] i_pc, i_instruction;
    logic            o_ready, o_valid;
    logic [XLEN-1:0] o_pc, o_instruction;
    logic [SCW-1:0]  o_stall_count;

    int checks = 0;
    int errors = 0;
    int stall_exp = 0;
    logic [63:0] exp_q[$];

    if_id_pipe_stage #(
        .XLEN        (XLEN),
        .RESET_PC    (RST_PC),
        .STALL_CNT_W (SCW)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_pc          (i_pc),
        .i_instruction (i_instruction),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_pc          (o_pc),
        .o_instruction (o_instruction),
        .i_flush       (i_flush),
        .o_stall_count (o_stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every decode-side transfer must match the oldest accepted entry.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready && !i_flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out actual_pc=%0h required=none t=%0t", o_pc, $time);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("out_pc", 64'(o_pc), 64'(e[63:32]));
                check("out_instr", 64'(o_instruction), 64'(e[31:0]));
            end
        end
    end

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cycle(input bit v, input bit r, input bit f,
                         input logic [31:0] pc, input logic [31:0] instr,
                         output bit accepted);
        bit rdy_exp;
        int n;
        i_valid = v; i_ready = r; i_flush = f; i_pc = pc; i_instruction = instr;
        #1;
        n = exp_q.size();
        rdy_exp = (CAP == 2) ? (n < 2) : ((n == 0) || r);
        check("o_ready", 64'(o_ready), 64'(rdy_exp));
        check("o_valid", 64'(o_valid), 64'(n > 0));
        check("stall_count", 64'(o_stall_count), 64'(stall_exp));
        if (n > 0 && !r && stall_exp < STAL_MAX) stall_exp++;
        accepted = v && rdy_exp && !f;
        if (f) begin
            exp_q.delete();
        end else if (accepted) begin
            exp_q.push_back({pc, instr});
        end
        @(posedge clk);
        #1;
        if (f) begin
            check("flush_valid", 64'(o_valid), 64'(0));
            check("flush_nop", 64'(o_instruction), 64'(NOP));
        end
    endtask

    task automatic check_reset_values();
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_pc", 64'(o_pc), 64'(RST_PC));
        check("rst_instr", 64'(o_instruction), 64'(NOP));
        check("rst_stall", 64'(o_stall_count), 64'(0));
        check("rst_ready", 64'(o_ready), 64'(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_valid = 0; i_ready = 0; i_flush = 0; i_pc = '0; i_instruction = '0;
        exp_q.delete();
        stall_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 4; k++) cycle(0, 1, 0, '0, '0, acc);
        check("drained", 64'(o_valid), 64'(0));
    endtask

    initial begin
        bit acc;
        logic [31:0] pc;
        int sent;

        do_reset();

        // Streaming with decode always ready.
        for (int k = 0; k < 3; k++) cycle(1, 1, 0, 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k), acc);
        drain();

        // Backpressure: i_ready low for three cycles mid-stream.
        pc = 32'h200; sent = 0;
        for (int k = 0; k < 12 && sent < 4; k++) begin
            cycle(1, !(k >= 2 && k <= 4), 0, pc, ~pc, acc);
            if (acc) begin pc += 4; sent++; end
        end
        drain();

        // Flush with both entries held and a third offered.
        do_reset();
        cycle(1, 0, 0, 32'h300, 32'hB300, acc);
        cycle(1, 0, 0, 32'h304, 32'hB304, acc);
        cycle(1, 0, 1, 32'h308, 32'hB308, acc);
        cycle(0, 1, 0, '0, '0, acc);
        drain();

        // Stall counter saturation.
        do_reset();
        cycle(1, 0, 0, 32'h400, 32'hC400, acc);
        for (int k = 0; k < 20; k++) cycle(0, 0, 0, '0, '0, acc);
        check("stall_sat", 64'(o_stall_count), 64'(STAL_MAX));
        drain();

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0,
                  $urandom, $urandom, acc);
        end

        // Reset asserted mid-cycle while entries are in flight.
        i_valid = 1; i_ready = 0; i_flush = 0; i_pc = 32'h500; i_instruction = 32'hD500;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        stall_exp = 0;
        i_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 200; k++) begin
            cycle(($urandom % 2) != 0, ($urandom % 2) != 0, ($urandom % 40) == 0,
                  $urandom, $urandom, acc);
        end
        drain();
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
